// File: rtl/hadamard_sequencer.sv
// -----------------------------------------------------------------------------
// hadamard_sequencer
//
// Purpose:
//   Applies a single-qubit Hadamard gate to qubit `target` across a full
//   2^N_QUBITS real-amplitude state vector that lives in an external
//   single-port RAM. For every amplitude pair (i0, i1 = i0 | 1<<target) the
//   controller reads both words, presents them to an external combinational
//   hadamard datapath, and writes the two results back in place.
//   Each pair takes 5 cycles (RD0, RD1, CAP, WR0, WR1). The done pulse comes
//   5*2^(N_QUBITS-1)+1 cycles after start.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      gate request, sampled only while idle
//   target     qubit index, sampled with start (>= N_QUBITS is rejected)
//   busy       high while a pass is in progress
//   done       one-cycle pulse at the end of a pass
//   error      one-cycle pulse on a rejected start (or an abort)
//   mem_addr   RAM address
//   mem_rd_en  RAM read strobe; data returns on mem_rdata one cycle later
//   mem_rdata  RAM read data (signed fixed point)
//   mem_wr_en  RAM write strobe
//   mem_wdata  RAM write data
//   h_in_a     hadamard in_real  (|0> amplitude of the current pair)
//   h_in_b     hadamard in_imag  (|1> amplitude of the current pair)
//   h_out_a    hadamard out_real
//   h_out_b    hadamard out_imag
//   abort      (only with HADAMARD_SEQ_ABORT_EN) cancels a pass in progress
//
// Build option:
//   HADAMARD_SEQ_ABORT_EN - adds the abort input. Without it every accepted
//   pass runs to completion.
// -----------------------------------------------------------------------------

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 16384
`endif
`ifndef FIXED_POINT_CONST_0_7071
`define FIXED_POINT_CONST_0_7071 11585
`endif

module hadamard_sequencer #(
    parameter int N_QUBITS = 3,
    parameter int ADDR_W   = N_QUBITS,
    parameter int TGT_W    = $clog2(N_QUBITS) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [TGT_W-1:0]        target,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd_en,
    input  logic [`FIXED_WIDTH-1:0] mem_rdata,
    output logic                    mem_wr_en,
    output logic [`FIXED_WIDTH-1:0] mem_wdata,
    output logic [`FIXED_WIDTH-1:0] h_in_a,
    output logic [`FIXED_WIDTH-1:0] h_in_b,
    input  logic [`FIXED_WIDTH-1:0] h_out_a,
    input  logic [`FIXED_WIDTH-1:0] h_out_b
`ifdef HADAMARD_SEQ_ABORT_EN
    ,
    input  logic                    abort
`endif
);

    localparam int W      = `FIXED_WIDTH;
    localparam int PAIR_W = N_QUBITS - 1;

    localparam logic [TGT_W-1:0]  TGT_LIMIT = TGT_W'(N_QUBITS);
    localparam logic [PAIR_W-1:0] LAST_PAIR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CAP,
        S_WR0,
        S_WR1,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [TGT_W-1:0]   tgt_reg;
    logic [PAIR_W-1:0]  pair_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       hb_reg;

    logic [PAIR_W-1:0]  pair_next;
    logic [ADDR_W-1:0]  i0;
    logic [ADDR_W-1:0]  i1;
    logic [ADDR_W-1:0]  i0_next;

    // Insert a 0 bit at position t into pair index p: bits below t stay put,
    // bits at and above t move up by one.
    function automatic logic [ADDR_W-1:0] pair_base(
        input logic [PAIR_W-1:0] p,
        input logic [TGT_W-1:0]  t
    );
        logic [ADDR_W-1:0] pe;
        logic [ADDR_W-1:0] low;
        pe  = ADDR_W'(p);
        low = (ADDR_W'(1) << t) - ADDR_W'(1);
        return ((pe & ~low) << 1) | (pe & low);
    endfunction

    assign pair_next = pair_reg + PAIR_W'(1);
    assign i0        = pair_base(pair_reg, tgt_reg);
    assign i1        = i0 | (ADDR_W'(1) << tgt_reg);
    assign i0_next   = pair_base(pair_next, tgt_reg);

    assign h_in_a = a_reg;
    assign h_in_b = b_reg;

    // The datapath result for the |0> word only becomes valid at the start of
    // WR0 (b is captured on the edge entering WR0), so that write takes
    // h_out_a straight through. The |1> result is held in hb_reg for WR1,
    // and hb_reg is also what the bus shows outside WR0 (zero after reset).
    assign mem_wdata = (state_reg == S_WR0) ? h_out_a : hb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            tgt_reg   <= '0;
            pair_reg  <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hb_reg    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (start) begin
                        if (target < TGT_LIMIT) begin
                            tgt_reg   <= target;
                            pair_reg  <= '0;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            // i0 of pair 0 is address 0 for every target.
                            mem_addr  <= '0;
                            state_reg <= S_RD0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_RD0: begin
                    mem_addr  <= i1;
                    state_reg <= S_RD1;
                end
                S_RD1: begin
                    // mem_rdata now carries the word read during RD0.
                    a_reg     <= mem_rdata;
                    mem_rd_en <= 1'b0;
                    state_reg <= S_CAP;
                end
                S_CAP: begin
                    b_reg     <= mem_rdata;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= i0;
                    state_reg <= S_WR0;
                end
                S_WR0: begin
                    hb_reg    <= h_out_b;
                    mem_addr  <= i1;
                    state_reg <= S_WR1;
                end
                S_WR1: begin
                    mem_wr_en <= 1'b0;
                    if (pair_reg == LAST_PAIR) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        pair_reg  <= pair_next;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= i0_next;
                        state_reg <= S_RD0;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

`ifdef HADAMARD_SEQ_ABORT_EN
            // Overrides whatever the case above scheduled. A write strobe on
            // the bus this cycle is still taken by the RAM at this edge.
            if (abort && (state_reg != S_IDLE)) begin
                state_reg <= S_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                error     <= 1'b1;
                mem_rd_en <= 1'b0;
                mem_wr_en <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hadamard_sequencer.sv
`timescale 1ns/1ps

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 16384
`endif
`ifndef FIXED_POINT_CONST_0_7071
`define FIXED_POINT_CONST_0_7071 11585
`endif

module tb_hadamard_sequencer;

    localparam int NQ    = 2;
    localparam int AW    = NQ;
    localparam int TW    = $clog2(NQ) + 1;
    localparam int W     = `FIXED_WIDTH;
    localparam int DEPTH = 1 << NQ;
    localparam int NP    = DEPTH / 2;
    localparam int FRAC  = $clog2(`SCALE_FACTOR);
    localparam int S     = `SCALE_FACTOR;
    localparam int C     = `FIXED_POINT_CONST_0_7071;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] target = '0;
    logic          busy, done, error, mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata, mem_wdata, h_in_a, h_in_b, h_out_a, h_out_b;
`ifdef HADAMARD_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    always #5 clk = ~clk;

    hadamard_sequencer #(.N_QUBITS(NQ)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target),
        .busy(busy), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .h_in_a(h_in_a), .h_in_b(h_in_b), .h_out_a(h_out_a), .h_out_b(h_out_b)
`ifdef HADAMARD_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    // ---------------- hadamard datapath (external block) ----------------
    function automatic int sat(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    function automatic int had_a(input int a, input int b);
        return sat(((longint'(a) + longint'(b)) * C) >>> FRAC);
    endfunction

    function automatic int had_b(input int a, input int b);
        return sat(((longint'(a) - longint'(b)) * C) >>> FRAC);
    endfunction

    assign h_out_a = W'(had_a(int'($signed(h_in_a)), int'($signed(h_in_b))));
    assign h_out_b = W'(had_b(int'($signed(h_in_a)), int'($signed(h_in_b))));

    // ---------------- state-vector RAM with a bench load port ----------------
    logic [W-1:0]  ram [DEPTH];
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;

    always @(posedge clk) begin
        if (load_en) ram[load_addr] <= load_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    function automatic int ram_val(input int i);
        return int'($signed(ram[i]));
    endfunction

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int model [DEPTH];
    int trace [$];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit busy, done, err, rd, wr, chk_addr, chk_wd;
        int addr;
        int wdata;
    } exp_t;

    exp_t exp_q [$];

    task automatic push(input int c, input bit bs, input bit dn, input bit er,
                        input bit rd, input bit wr, input bit ca, input int ad,
                        input bit cw, input int wd);
        exp_t e;
        e.cyc = c; e.busy = bs; e.done = dn; e.err = er; e.rd = rd; e.wr = wr;
        e.chk_addr = ca; e.addr = ad; e.chk_wd = cw; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    task automatic chk(input bit ok, input string name, input int got, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Per-cycle compare: a queued expectation for this cycle, otherwise idle.
    always @(negedge clk) begin
        exp_t e;
        bit ok;
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
            end else begin
                e.cyc = cyc; e.busy = 0; e.done = 0; e.err = 0; e.rd = 0; e.wr = 0;
                e.chk_addr = 0; e.addr = 0; e.chk_wd = 0; e.wdata = 0;
            end
            ok = (busy === e.busy) && (done === e.done) && (error === e.err) &&
                 (mem_rd_en === e.rd) && (mem_wr_en === e.wr) &&
                 !(mem_rd_en && mem_wr_en) &&
                 (!e.chk_addr || (int'(mem_addr) == e.addr)) &&
                 (!e.chk_wd || (int'($signed(mem_wdata)) == e.wdata));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle cyc=%0d got busy=%0b done=%0b err=%0b rd=%0b wr=%0b addr=%0d wdata=%0d, expected busy=%0b done=%0b err=%0b rd=%0b wr=%0b addr=%0d wdata=%0d",
                         cyc, busy, done, error, mem_rd_en, mem_wr_en, mem_addr,
                         $signed(mem_wdata), e.busy, e.done, e.err, e.rd, e.wr,
                         e.addr, e.wdata);
            end
        end
    end

    // Expected bus activity of a whole pass started at cycle n, computed from
    // the pair enumeration rule; the model array is advanced for the first
    // upd pairs (all of them for a normal pass).
    task automatic push_pass(input int n, input int t, input int upd);
        int i0, i1, a, b, base;
        for (int p = 0; p < NP; p++) begin
            i0 = (p / (1 << t)) * (2 << t) + p % (1 << t);
            i1 = i0 + (1 << t);
            a = model[i0];
            b = model[i1];
            base = n + 1 + 5 * p;
            push(base,     1, 0, 0, 1, 0, 1, i0, 0, 0);
            push(base + 1, 1, 0, 0, 1, 0, 1, i1, 0, 0);
            push(base + 2, 1, 0, 0, 0, 0, 0, 0,  0, 0);
            push(base + 3, 1, 0, 0, 0, 1, 1, i0, 1, had_a(a, b));
            push(base + 4, 1, 0, 0, 0, 1, 1, i1, 1, had_b(a, b));
            if (p < upd) begin
                model[i0] = had_a(a, b);
                model[i1] = had_b(a, b);
            end
        end
        push(n + 1 + 5 * NP, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_ram(input int v0, input int v1, input int v2, input int v3);
        int v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            load_en = 1'b1;
            load_addr = AW'(i);
            load_data = W'(v[i]);
            model[i] = v[i];
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // One start request; inj > 0 pulses a second start k cycles into the pass.
    task automatic run_pass(input int t, input int inj, output int done_dist, output int nwr);
        int n, len;
        @(negedge clk);
        start = 1'b1;
        target = TW'(t);
        n = cyc;
        if (t < NQ) begin
            push_pass(n, t, NP);
            len = 5 * NP + 3;
        end else begin
            push(n + 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            len = 3;
        end
        done_dist = -1;
        nwr = 0;
        trace.delete();
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start = (k == inj);
            if (k == inj) target = TW'($urandom_range(0, (1 << TW) - 1));
            if (mem_rd_en || mem_wr_en) trace.push_back(int'(mem_addr));
            if (mem_wr_en) nwr++;
            if (done) done_dist = cyc - n;
        end
        start = 1'b0;
    endtask

    task automatic check_ram_model(input string name);
        for (int i = 0; i < DEPTH; i++) chk(ram_val(i) == model[i], name, ram_val(i), model[i]);
    endtask

    task automatic check_ram_near(input string name, input int e0, input int e1,
                                  input int e2, input int e3, input int tol);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < DEPTH; i++)
            chk(absi(ram_val(i) - e[i]) <= tol, name, ram_val(i), e[i]);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({busy, done, error, mem_rd_en, mem_wr_en} === 5'b0, {name, "_ctrl"},
            int'({busy, done, error, mem_rd_en, mem_wr_en}), 0);
        chk(mem_addr === '0 && mem_wdata === '0, {name, "_bus"},
            int'(mem_addr) + int'(mem_wdata), 0);
        chk(h_in_a === '0 && h_in_b === '0, {name, "_hin"},
            int'(h_in_a) + int'(h_in_b), 0);
    endtask

    initial begin
        int dd, nw, n;
        int exp_tr [8];

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Target 0 on [S,0,0,0]
        load_ram(S, 0, 0, 0);
        run_pass(0, 0, dd, nw);
        chk(dd == 5 * NP + 1, "done_latency", dd, 11);
        check_ram_near("t0_literal", C, C, 0, 0, 2);
        check_ram_model("t0_model");

        // Target 1, address trace
        load_ram(S, 0, 0, 0);
        run_pass(1, 0, dd, nw);
        exp_tr[0] = 0; exp_tr[1] = 2; exp_tr[2] = 0; exp_tr[3] = 2;
        exp_tr[4] = 1; exp_tr[5] = 3; exp_tr[6] = 1; exp_tr[7] = 3;
        chk(trace.size() == 8, "t1_trace_len", trace.size(), 8);
        for (int i = 0; i < 8 && i < trace.size(); i++)
            chk(trace[i] == exp_tr[i], "t1_trace_addr", trace[i], exp_tr[i]);
        check_ram_near("t1_literal", C, 0, C, 0, 2);

        // Two passes return to the start, with a start pulsed mid-pass
        load_ram(S, 0, 0, 0);
        run_pass(0, 4, dd, nw);
        chk(dd == 11, "double_first_done", dd, 11);
        run_pass(0, 7, dd, nw);
        check_ram_near("double_literal", S, 0, 0, 0, 5);
        check_ram_model("double_model");

        // Out-of-range target
        load_ram(S, 0, 0, 0);
        run_pass(2, 0, dd, nw);
        chk(nw == 0 && trace.size() == 0, "bad_target_strobes", trace.size(), 0);
        check_ram_near("bad_target_ram", S, 0, 0, 0, 0);

        // Reset during WR0 of pair 1
        load_ram(S, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        target = TW'(0);
        n = cyc;
        push_pass(n, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        chk(mem_wr_en === 1'b1 && int'(mem_addr) == 2, "pre_reset_wr0", int'(mem_addr), 2);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midpass_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_ram_model("after_reset_ram");
        run_pass(0, 0, dd, nw);
        chk(dd == 11, "after_reset_done", dd, 11);
        check_ram_model("after_reset_pass");

`ifdef HADAMARD_SEQ_ABORT_EN
        // Abort in RD1 of pair 0
        load_ram(S, 0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        target = TW'(0);
        n = cyc;
        push(n + 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        push(n + 2, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        push(n + 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        nw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            abort = 1'b0;
            if (mem_wr_en) nw++;
        end
        chk(nw == 0, "abort_no_writes", nw, 0);
        check_ram_near("abort_ram", S, 0, 0, 0, 0);
`endif

        // Randomized passes against the model
        for (int it = 0; it < 12; it++) begin
            int t, inj;
            load_ram(int'($urandom_range(0, 12000)) - 6000, int'($urandom_range(0, 12000)) - 6000,
                     int'($urandom_range(0, 12000)) - 6000, int'($urandom_range(0, 12000)) - 6000);
            t = int'($urandom_range(0, 3));
            inj = (t < NQ && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5 * NP)) : 0;
            run_pass(t, inj, dd, nw);
            if (t < NQ) chk(dd == 5 * NP + 1, "rand_done", dd, 5 * NP + 1);
            else chk(nw == 0, "rand_bad_no_writes", nw, 0);
            check_ram_model("rand_ram");
        end

        @(negedge clk);
        chk(exp_q.size() == 0, "expect_queue_drained", exp_q.size(), 0);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
